seq_addsub: RTL and testbench
=============================

SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands and op are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result outputs are valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-013 cout  output  1  raw carry out of MSB.
REQ-014 overflow  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  sum equals 0.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE.
REQ-017 IDLE: in_valid && in_ready at an edge captures a, b, sub, sets carry = sub, chunk index = 0, goes to CALC.
REQ-018 Subtraction SHALL be computed as a + ~b + 1; operands registered at accept, later input changes ignored.
REQ-019 CALC: each edge adds chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of a and effective b plus carry, writes sum chunk k, registers carry out, increments k.
REQ-020 After chunk N-1, go to DONE; out_valid SHALL rise exactly N edges after the accepting edge (CHUNK = WIDTH gives 1 cycle).
REQ-021 cout = final carry; for sub, cout = 1 means no borrow.
REQ-022 overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), b_eff = sub ? ~b : b.
REQ-023 DONE: sum, cout, overflow, zero SHALL be held stable while out_valid && !out_ready.
REQ-024 DONE with out_ready at an edge returns to IDLE; in_ready SHALL be 1 the following cycle (no accept in the same cycle as result handoff).
REQ-025 sum SHALL hold the previous result in IDLE until the next accept; partial sums SHALL not be qualified by out_valid.
REQ-026 in_valid during CALC or DONE SHALL be ignored (no capture, no state change).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, sum 0, cout 0, overflow 0, zero 0, carry 0, chunk index 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result delivered.
REQ-029 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SEQ_ADDSUB_FLAGS_EN defined: overflow and zero computed per REQ-015/REQ-022, registered at entry to DONE.
REQ-031 Macro undefined: overflow and zero SHALL be constant 0, no flag logic synthesised; sum, cout, timing unchanged.

Verification (WIDTH=32, CHUNK=8, macro defined unless stated)
REQ-032 a=FFFFFFFF, b=00000001, sub=0 -> sum=00000000, cout=1, zero=1, overflow=0, out_valid 4 edges after accept.
REQ-033 a=7FFFFFFF, b=00000001, sub=0 -> sum=80000000, cout=0, overflow=1, zero=0.
REQ-034 a=80000000, b=00000001, sub=1 -> sum=7FFFFFFF, cout=1, overflow=1; a=0, b=1, sub=1 -> sum=FFFFFFFF, cout=0, overflow=0.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE, a/b/in_valid toggling -> outputs unchanged, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst_n pulsed low during 2nd CALC cycle -> all outputs reset values at once, no out_valid; next op after release completes in 4 cycles.
REQ-037 Macro undefined, a=7FFFFFFF, b=1 -> sum=80000000, overflow=0, zero=0; plus 200 random ops with CHUNK in {1,8,32} matching a±b reference model.

Source files
------------

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, ripple carry held in a flop.
// Define SEQ_ADDSUB_FLAGS_EN to build the overflow/zero flag registers.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N   = WIDTH / CHUNK;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CHUNK:0]   csum;
  logic             last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
    csum    = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
    last    = (k_q == KW'(N - 1));
    case (state_q)
      IDLE: if (in_valid) begin
        // b is stored already inverted for subtract; carry-in supplies the +1
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub;
        k_d     = '0;
        state_d = CALC;
      end
      CALC: begin
        sum_d[k_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        k_d     = k_q + 1'b1;
        if (last) begin
          k_d     = '0;
          cout_d  = csum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef SEQ_ADDSUB_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d;

  // Flags latch from the fully assembled sum on the final CALC edge.
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (state_q == CALC && last) begin
      ovf_d  = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
      zero_d = (sum_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench: three seq_addsub instances (CHUNK 8, 1, 32) share stimulus;
// expected results come from plain signed/unsigned arithmetic.
module tb_seq_addsub;
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, sub;
  logic [31:0] a, b;
  logic [2:0]  in_ready_w, out_valid_w, cout_w, ovf_w, zero_w;
  logic [31:0] sum_w [3];

  int   tests = 0, fails = 0, cyc = 0;
  int   NS [3] = '{4, 32, 1};
  exp_t sbq [3][$];
  exp_t me;
  int   rise [3];
  logic [2:0] ov_prev = '0, rdy_chk = '0;
  logic rnd_bp = 1'b0;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .cout(cout_w[0]), .overflow(ovf_w[0]), .zero(zero_w[0]));
  seq_addsub #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .cout(cout_w[1]), .overflow(ovf_w[1]), .zero(zero_w[1]));
  seq_addsub #(.WIDTH(32), .CHUNK(32)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .cout(cout_w[2]), .overflow(ovf_w[2]), .zero(zero_w[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic s);
    exp_t   e;
    longint sa = longint'($signed(aa));
    longint sb = longint'($signed(bb));
    longint sr;
    logic [32:0] full;
    if (s) begin
      e.s = aa - bb;
      e.c = (aa >= bb);
      sr  = sa - sb;
    end else begin
      full = {1'b0, aa} + {1'b0, bb};
      e.s  = full[31:0];
      e.c  = full[32];
      sr   = sa + sb;
    end
`ifdef SEQ_ADDSUB_FLAGS_EN
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z = (e.s == 32'd0);
`else
    e.o = 1'b0;
    e.z = 1'b0;
`endif
    e.acc = 0;
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (in_ready_w != 3'b111 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL wait_idle timeout: in_ready=%b", in_ready_w);
    end
  endtask

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic s);
    exp_t e;
    wait_idle();
    a = aa; b = bb; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_in_ready_low", {29'd0, in_ready_w}, 32'd0);
    e = model(aa, bb, s);
    e.acc = cyc;
    for (int i = 0; i < 3; i++) sbq[i].push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d in_ready", tag, i), in_ready_w[i], 1);
      chk($sformatf("%s u%0d out_valid", tag, i), out_valid_w[i], 0);
      chk($sformatf("%s u%0d sum", tag, i), sum_w[i], 0);
      chk($sformatf("%s u%0d cout", tag, i), cout_w[i], 0);
      chk($sformatf("%s u%0d overflow", tag, i), ovf_w[i], 0);
      chk($sformatf("%s u%0d zero", tag, i), zero_w[i], 0);
    end
  endtask

  // Monitor: pops on handshake; while held, the front entry is re-checked every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = '0;
      rdy_chk = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rdy_chk[i]) begin
          chk($sformatf("u%0d in_ready_after_handoff", i), in_ready_w[i], 1);
          rdy_chk[i] = 1'b0;
        end
        if (out_valid_w[i]) begin
          if (!ov_prev[i]) rise[i] = cyc;
          if (sbq[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL u%0d unexpected out_valid sum=%h", i, sum_w[i]);
          end else begin
            me = sbq[i][0];
            chk($sformatf("u%0d sum", i), sum_w[i], me.s);
            chk($sformatf("u%0d cout", i), cout_w[i], me.c);
            chk($sformatf("u%0d overflow", i), ovf_w[i], me.o);
            chk($sformatf("u%0d zero", i), zero_w[i], me.z);
            chk($sformatf("u%0d in_ready_in_done", i), in_ready_w[i], 0);
            if (out_ready) begin
              chk($sformatf("u%0d latency", i), rise[i] - me.acc, NS[i]);
              void'(sbq[i].pop_front());
              rdy_chk[i] = 1'b1;
            end
          end
        end
        ov_prev[i] = out_valid_w[i];
      end
    end
  end

  always @(posedge clk) if (rnd_bp) begin
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_idle();
    chk("sum_hold_idle", sum_w[0], 32'h80000000);
    issue(32'h80000000, 32'h00000001, 1'b1);
    issue(32'h00000000, 32'h00000001, 1'b1);
    issue(32'h12345678, 32'h12345678, 1'b1);

    // Backpressure with garbage inputs toggling while the result is held
    wait_idle();
    @(posedge clk); #1 out_ready = 1'b0;
    issue(32'hDEADBEEF, 32'h01020304, 1'b0);
    begin
      int n = 0;
      while (!out_valid_w[0] && n < 50) begin @(negedge clk); n++; end
      chk("bp_reach_done", out_valid_w[0], 1);
    end
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom; sub = $urandom_range(0, 1); in_valid = ~in_valid;
      @(negedge clk);
      chk("bp_in_ready", in_ready_w[0], 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset in the second CALC cycle of u0 aborts everything
    wait_idle();
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) sbq[i].delete();
    #1 chk_reset("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("first_accept_after_reset", in_ready_w[0], 0);
    me = model(32'h0000FFFF, 32'h00000001, 1'b0);
    me.acc = cyc;
    for (int i = 0; i < 3; i++) sbq[i].push_back(me);

    // Random ops with random consumer stalls
    wait_idle();
    rnd_bp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 32'h80000000;
        2: rb = 32'h7FFFFFFF;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rnd_bp = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d scoreboard_drained", i), sbq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
